color_window_cache: RTL and testbench

Parametrised multi-channel pixel window cache for the colour datapath. Each channel holds a short line of pixels. The block presents the oldest WIN_PIX pixels of every channel as one flat window word. Words are appended per channel through a valid/ready load port, and pixel counts are tracked. The consumer slides the window one pixel at a time, and the block refuses a shift unless every channel holds a full window.

---
 rtl/color_window_cache.sv | 130 +++++++++++++
 tb/tb_color_window_cache.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/color_window_cache.sv
// color_window_cache: per-channel pixel line buffers that present the oldest
// WIN_PIX pixels of every channel as one flat window word. Words are appended
// per channel through a valid/ready port. The consumer slides the window one
// pixel at a time, and a slide is only taken when every channel holds a full
// window.
module color_window_cache #(
  parameter int CHANNELS    = 3,
  parameter int WORD_W      = 16,
  parameter int PIX_W       = 8,
  parameter int DEPTH_WORDS = 2,
  parameter int WIN_PIX     = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   ld_valid_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ld_ch_i,
  input  logic [WORD_W-1:0]                      ld_data_i,
  output logic [CHANNELS-1:0]                    ld_ready_o,
  input  logic                                   sh_i,
  output logic [CHANNELS*WIN_PIX*PIX_W-1:0]      win_out_o,
  output logic                                   win_valid_o,
  output logic [CHANNELS*($clog2(DEPTH_WORDS*WORD_W/PIX_W)+1)-1:0] cnt_out_o,
  output logic                                   sh_err_o
);

  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PPW       = WORD_W / PIX_W;
  localparam int DEPTH_PIX = DEPTH_WORDS * PPW;
  localparam int CNT_W     = $clog2(DEPTH_PIX) + 1;
  localparam int BUF_W     = DEPTH_PIX * PIX_W;
  localparam int WIN_W     = WIN_PIX * PIX_W;

  // Slot 0 of each buffer is the MSB slice and holds the oldest pixel.
  // Slots at or beyond the count are kept at zero, so a load can simply OR
  // its word into place.
  logic [BUF_W-1:0]    buf_q [CHANNELS];
  logic [BUF_W-1:0]    buf_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic                sh_err_q;
  logic                sh_err_d;

  logic                win_valid;
  logic [CHANNELS-1:0] ld_ready;
  logic [CHANNELS-1:0] ld_acc;
  logic                sh_acc;
  logic [BUF_W-1:0]    ld_ext;

  // Window-valid and per-channel space flags, both taken from the
  // pre-shift counts so that ready is conservative when a shift coincides.
  always_comb begin
    win_valid = 1'b1;
    ld_ready  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cnt_q[c] < CNT_W'(WIN_PIX)) begin
        win_valid = 1'b0;
      end
      ld_ready[c] = (({1'b0, cnt_q[c]} + (CNT_W+1)'(PPW)) <= (CNT_W+1)'(DEPTH_PIX));
    end
  end

  assign sh_acc = sh_i & win_valid & ~flush_i;

  // Load accept per channel; a channel index beyond CHANNELS matches nothing
  // and is therefore dropped.
  always_comb begin
    ld_acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ld_acc[c] = ld_valid_i & ~flush_i & ld_ready[c] & (ld_ch_i == CH_W'(c));
    end
  end

  // Next-state: flush wins outright; otherwise the shift applies first and a
  // load then lands right after the post-shift count of its channel.
  always_comb begin
    sh_err_d = sh_err_q | (sh_i & ~win_valid & ~flush_i);
    ld_ext   = '0;
    ld_ext[BUF_W-1 -: WORD_W] = ld_data_i;
    for (int c = 0; c < CHANNELS; c++) begin
      buf_d[c] = buf_q[c];
      cnt_d[c] = cnt_q[c];
      if (flush_i) begin
        buf_d[c] = '0;
        cnt_d[c] = '0;
      end else begin
        if (sh_acc) begin
          buf_d[c] = buf_q[c] << PIX_W;
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
        if (ld_acc[c]) begin
          buf_d[c] = buf_d[c] | (ld_ext >> (int'(cnt_d[c]) * PIX_W));
          cnt_d[c] = cnt_d[c] + CNT_W'(PPW);
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        buf_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      sh_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        buf_q[c] <= buf_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      sh_err_q <= sh_err_d;
    end
  end

  // Flatten windows and counts with channel 0 in the MSBs.
  always_comb begin
    win_out_o = '0;
    cnt_out_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      win_out_o[(CHANNELS-1-c)*WIN_W +: WIN_W] = buf_q[c][BUF_W-1 -: WIN_W];
      cnt_out_o[(CHANNELS-1-c)*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

  assign win_valid_o = win_valid;
  assign ld_ready_o  = ld_ready;
  assign sh_err_o    = sh_err_q;

endmodule

// File: tb/tb_color_window_cache.sv
// Directed bench for color_window_cache: default three-channel build plus a
// four-channel, single-word-deep build driven from the same clock.
module tb_color_window_cache;

  logic clk;
  logic rst;

  // Default build: 3 channels, 16-bit words, 4 pixels deep, 3-pixel window.
  logic        flush, ldValid, sh;
  logic [1:0]  ldCh;
  logic [15:0] ldData;
  logic [2:0]  ldReady;
  logic [71:0] winOut;
  logic        winValid;
  logic [8:0]  cntOut;
  logic        shErr;

  // Wide build: 4 channels, 32-bit words, 4 pixels deep, 2-pixel window.
  logic        flushB, ldValidB, shB;
  logic [1:0]  ldChB;
  logic [31:0] ldDataB;
  logic [3:0]  ldReadyB;
  logic [63:0] winOutB;
  logic        winValidB;
  logic [11:0] cntOutB;
  logic        shErrB;

  int checkCount = 0;
  int passCount  = 0;

  color_window_cache dutA (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .ld_valid_i  (ldValid),
    .ld_ch_i     (ldCh),
    .ld_data_i   (ldData),
    .ld_ready_o  (ldReady),
    .sh_i        (sh),
    .win_out_o   (winOut),
    .win_valid_o (winValid),
    .cnt_out_o   (cntOut),
    .sh_err_o    (shErr)
  );

  color_window_cache #(
    .CHANNELS    (4),
    .WORD_W      (32),
    .PIX_W       (8),
    .DEPTH_WORDS (1),
    .WIN_PIX     (2)
  ) dutB (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flushB),
    .ld_valid_i  (ldValidB),
    .ld_ch_i     (ldChB),
    .ld_data_i   (ldDataB),
    .ld_ready_o  (ldReadyB),
    .sh_i        (shB),
    .win_out_o   (winOutB),
    .win_valid_o (winValidB),
    .cnt_out_o   (cntOutB),
    .sh_err_o    (shErrB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle on the default build, then return inputs to idle.
  task automatic applyStimulus(input logic f, input logic v, input logic [1:0] ch,
                               input logic [15:0] d, input logic s);
    flush = f; ldValid = v; ldCh = ch; ldData = d; sh = s;
    @(posedge clk); #1;
    flush = 1'b0; ldValid = 1'b0; ldCh = 2'd0; ldData = 16'h0; sh = 1'b0;
  endtask

  // Drive one cycle on the wide build, then return inputs to idle.
  task automatic applyStimulusB(input logic v, input logic [1:0] ch,
                                input logic [31:0] d, input logic s);
    flushB = 1'b0; ldValidB = v; ldChB = ch; ldDataB = d; shB = s;
    @(posedge clk); #1;
    ldValidB = 1'b0; ldChB = 2'd0; ldDataB = 32'h0; shB = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; ldValid = 1'b0; ldCh = 2'd0; ldData = 16'h0; sh = 1'b0;
    flushB = 1'b0; ldValidB = 1'b0; ldChB = 2'd0; ldDataB = 32'h0; shB = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_win",     winOut,   72'h0);
    checkOutput("rst_valid",   winValid, 1'b0);
    checkOutput("rst_cnt",     cntOut,   9'h0);
    checkOutput("rst_ready",   ldReady,  3'b111);
    checkOutput("rst_sherr",   shErr,    1'b0);
    checkOutput("rst_readyB",  ldReadyB, 4'b1111);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] fill all channels");
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hAABB, 1'b0);
    checkOutput("s1_cnt_half", cntOut, 9'b010_000_000);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hCCDD, 1'b0);
    checkOutput("s1_ready_ch0", ldReady, 3'b110);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h1122, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h3344, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h5566, 1'b0);
    checkOutput("s1_valid_pre", winValid, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h7788, 1'b0);
    checkOutput("s1_cnt",   cntOut,   9'b100_100_100);
    checkOutput("s1_ready", ldReady,  3'b000);
    checkOutput("s1_valid", winValid, 1'b1);
    checkOutput("s1_win",   winOut,   72'hAABBCC_112233_556677);

    $display("[TB] slide window");
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    checkOutput("s2_win1", winOut, 72'hBBCCDD_223344_667788);
    checkOutput("s2_cnt1", cntOut, 9'b011_011_011);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    checkOutput("s2_win2",   winOut,   72'hCCDD00_334400_778800);
    checkOutput("s2_cnt2",   cntOut,   9'b010_010_010);
    checkOutput("s2_valid2", winValid, 1'b0);
    checkOutput("s2_sherr",  shErr,    1'b0);

    $display("[TB] rejected shift with load");
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hEEFF, 1'b1);
    checkOutput("s3_sherr", shErr,    1'b1);
    checkOutput("s3_cnt",   cntOut,   9'b100_010_010);
    checkOutput("s3_win",   winOut,   72'hCCDDEE_334400_778800);
    checkOutput("s3_valid", winValid, 1'b0);
    checkOutput("s3_ready", ldReady,  3'b110);

    $display("[TB] conservative ready around a shift");
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h5A5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h6B6B, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    checkOutput("s4_cnt3",   cntOut,  9'b011_011_011);
    checkOutput("s4_ready3", ldReady, 3'b000);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h9999, 1'b1);
    checkOutput("s4_cnt2",   cntOut,  9'b010_010_010);
    checkOutput("s4_ready2", ldReady, 3'b111);
    checkOutput("s4_win2",   winOut,  72'hEEFF00_5A5A00_6B6B00);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h9999, 1'b0);
    checkOutput("s4_cnt_ld", cntOut,  9'b010_100_010);
    checkOutput("s4_win_ld", winOut,  72'hEEFF00_5A5A99_6B6B00);
    checkOutput("s4_ready",  ldReady, 3'b101);

    $display("[TB] flush over shift and load");
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h5678, 1'b0);
    checkOutput("s5_full_win", winOut,   72'hEEFF12_5A5A99_6B6B56);
    checkOutput("s5_full_val", winValid, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 16'hFFFF, 1'b1);
    checkOutput("s5_cnt",   cntOut,   9'h0);
    checkOutput("s5_win",   winOut,   72'h0);
    checkOutput("s5_valid", winValid, 1'b0);
    checkOutput("s5_sherr", shErr,    1'b1);
    checkOutput("s5_ready", ldReady,  3'b111);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'h4321, 1'b0);
    checkOutput("s5_badch", cntOut, 9'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hABCD, 1'b0);
    checkOutput("s5_reload", winOut, 72'hABCD00_000000_000000);

    $display("[TB] asynchronous reset mid-cycle");
    #3 rst = 1'b1;
    #1;
    checkOutput("s6_rst_cnt",   cntOut, 9'h0);
    checkOutput("s6_rst_win",   winOut, 72'h0);
    checkOutput("s6_rst_sherr", shErr,  1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h0102, 1'b0);
    checkOutput("s6_after_rst", cntOut, 9'b000_000_010);

    $display("[TB] wide build");
    applyStimulusB(1'b1, 2'd0, 32'h11223344, 1'b0);
    applyStimulusB(1'b1, 2'd1, 32'h55667788, 1'b0);
    applyStimulusB(1'b1, 2'd2, 32'h99AABBCC, 1'b0);
    checkOutput("b_valid_pre", winValidB, 1'b0);
    checkOutput("b_ready_pre", ldReadyB,  4'b1000);
    applyStimulusB(1'b1, 2'd3, 32'hDDEEFF00, 1'b0);
    checkOutput("b_cnt",   cntOutB,   12'b100_100_100_100);
    checkOutput("b_ready", ldReadyB,  4'b0000);
    checkOutput("b_valid", winValidB, 1'b1);
    checkOutput("b_win",   winOutB,   64'h1122_5566_99AA_DDEE);
    applyStimulusB(1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("b_win_sh", winOutB,  64'h2233_6677_AABB_EEFF);
    checkOutput("b_cnt_sh", cntOutB,  12'b011_011_011_011);
    checkOutput("b_sherr",  shErrB,   1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
